// File: rtl/sample_packetizer.sv
// Frames 16-bit AXI-Stream samples into SYNC/SEQ/LEN/payload/CSUM byte packets
// for the FT232H sync-FIFO controller; all outputs are registered.
module sample_packetizer #(
  parameter int unsigned SAMPLES_PER_PACKET = 4,
  parameter logic [7:0]  SYNC_BYTE          = 8'hA5
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [15:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_SEQ, ST_LEN, ST_LOAD, ST_HI, ST_LO, ST_CSUM
  } state_t;

  localparam logic [7:0] LEN_BYTE = 8'(SAMPLES_PER_PACKET);
  localparam logic [7:0] LAST_IDX = 8'(SAMPLES_PER_PACKET - 1);

  state_t      state;
  logic [7:0]  seq;
  logic [7:0]  cnt;
  logic [7:0]  acc;
  logic [15:0] sample;

  // Outputs are loaded with the value for the state being entered, so every
  // output is a flop and nothing combinational reaches the ports.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      seq      <= '0;
      cnt      <= '0;
      acc      <= '0;
      sample   <= '0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      s_tready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          acc <= '0;
          cnt <= '0;
          if (s_tvalid) begin
            state    <= ST_SYNC;
            m_tvalid <= 1'b1;
            m_tdata  <= SYNC_BYTE;
            busy     <= 1'b1;
          end
        end
        ST_SYNC: if (m_tready) begin
          state   <= ST_SEQ;
          m_tdata <= seq;
        end
        ST_SEQ: if (m_tready) begin
          acc     <= acc + seq;
          state   <= ST_LEN;
          m_tdata <= LEN_BYTE;
        end
        ST_LEN: if (m_tready) begin
          acc      <= acc + LEN_BYTE;
          state    <= ST_LOAD;
          m_tvalid <= 1'b0;
          m_tdata  <= '0;
          s_tready <= 1'b1;
        end
        ST_LOAD: if (s_tvalid) begin
          sample   <= s_tdata;
          state    <= ST_HI;
          s_tready <= 1'b0;
          m_tvalid <= 1'b1;
          m_tdata  <= s_tdata[15:8];
        end
        ST_HI: if (m_tready) begin
          acc     <= acc + sample[15:8];
          state   <= ST_LO;
          m_tdata <= sample[7:0];
        end
        ST_LO: if (m_tready) begin
          acc <= acc + sample[7:0];
          if (cnt == LAST_IDX) begin
            cnt     <= '0;
            state   <= ST_CSUM;
            m_tdata <= acc + sample[7:0];
          end else begin
            cnt      <= cnt + 8'd1;
            state    <= ST_LOAD;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            s_tready <= 1'b1;
          end
        end
        ST_CSUM: if (m_tready) begin
          seq      <= seq + 8'd1;
          state    <= ST_IDLE;
          m_tvalid <= 1'b0;
          m_tdata  <= '0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          m_tvalid <= 1'b0;
          s_tready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_packetizer.sv
// Randomized bench for sample_packetizer: expected frames are built from the
// frame-format rules and compared byte-for-byte with the captured stream.
module tb_sample_packetizer;

  localparam int         N    = 4;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         FLEN = 4 + 2 * N;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        busy;

  sample_packetizer #(.SAMPLES_PER_PACKET(N), .SYNC_BYTE(SYNC)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .s_tdata (s_tdata),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_tdata (m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .busy    (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int          start_cyc[$];
  int          cyc = 0;
  int          fpos = 0;
  int          gap = 0;
  int          gap_max = 0;
  int          ready_pct = 100;
  logic        s_acc = 1'b0;
  logic        stall_prev = 1'b0;
  logic [7:0]  data_prev = '0;
  logic [7:0]  model_seq = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: a frame is SYNC, SEQ, LEN, payload MSB first, then the mod-256
  // sum of everything after SYNC.
  task automatic add_frame(input logic [15:0] s [N]);
    logic [7:0] csum;
    csum = model_seq + 8'(N);
    exp_q.push_back(SYNC);
    exp_q.push_back(model_seq);
    exp_q.push_back(8'(N));
    for (int i = 0; i < N; i++) begin
      tx_q.push_back(s[i]);
      exp_q.push_back(s[i][15:8]);
      exp_q.push_back(s[i][7:0]);
      csum = csum + s[i][15:8] + s[i][7:0];
    end
    exp_q.push_back(csum);
    model_seq = model_seq + 8'd1;
  endtask

  task automatic add_random_frame();
    logic [15:0] s [N];
    for (int i = 0; i < N; i++) s[i] = 16'($urandom);
    add_frame(s);
  endtask

  // One cycle: inputs change at the falling edge, and the handshakes the next
  // rising edge will see are recorded from the registered outputs.
  task automatic step();
    @(negedge sys_clk);
    cyc++;
    if (stall_prev) begin
      check("hold_valid", 32'(m_tvalid), 32'd1);
      check("hold_data", 32'(m_tdata), 32'(data_prev));
    end
    if (s_tready) check("sready_only_load", 32'(m_tvalid), 32'd0);
    if (s_acc) begin
      s_tvalid = 1'b0;
      s_acc    = 1'b0;
      gap      = $urandom_range(gap_max);
    end
    if (!s_tvalid) begin
      if (gap > 0) gap--;
      else if (tx_q.size() > 0) begin
        s_tvalid = 1'b1;
        s_tdata  = tx_q[0];
      end
    end
    m_tready = ($urandom_range(99) < ready_pct);
    if (m_tvalid && m_tready) begin
      rx_q.push_back(m_tdata);
      if (fpos == 0) start_cyc.push_back(cyc);
      fpos = (fpos + 1) % FLEN;
    end
    if (s_tvalid && s_tready) begin
      void'(tx_q.pop_front());
      s_acc = 1'b1;
    end
    stall_prev = m_tvalid && !m_tready;
    data_prev  = m_tdata;
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < target && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(rx_q.size() >= target), 32'd1);
  endtask

  task automatic compare_bytes(input string tag);
    int n;
    n = exp_q.size();
    check({tag, "_len"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_periods();
    for (int i = 1; i < start_cyc.size(); i++)
      check("frame_period", 32'(start_cyc[i] - start_cyc[i-1]), 32'(5 + 3 * N));
    start_cyc.delete();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
    check({tag, "_m_tdata"},  32'(m_tdata),  32'd0);
    check({tag, "_s_tready"}, 32'(s_tready), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
  endtask

  initial begin
    logic [15:0] d [N];

    #1;
    check_quiet("reset");
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Directed frame with m_tready held high.
    d = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF};
    add_frame(d);
    step();
    check("idle_before_sync", 32'(m_tvalid), 32'd0);
    @(posedge sys_clk);
    #1;
    check("sync_latency_valid", 32'(m_tvalid), 32'd1);
    check("sync_latency_data", 32'(m_tdata), 32'(SYNC));
    check("busy_in_frame", 32'(busy), 32'd1);
    run_until(FLEN, 200, "dir_timeout");
    if (rx_q.size() == FLEN) begin
      check("dir_seq0", 32'(rx_q[1]), 32'h00);
      check("dir_csum", 32'(rx_q[FLEN-1]), 32'hC0);
    end
    compare_bytes("dir");
    step();
    check("busy_after_csum", 32'(busy), 32'd0);
    check("valid_after_csum", 32'(m_tvalid), 32'd0);
    start_cyc.delete();

    // 257 back-to-back frames: SEQ wraps, period is 5+3N.
    for (int f = 0; f < 257; f++) add_random_frame();
    run_until(257 * FLEN, 8000, "wrap_timeout");
    compare_bytes("wrap");
    check_periods();
    check("model_seq_wrapped", 32'(model_seq), 32'd2);

    // Random backpressure and sample gaps.
    ready_pct = 50;
    gap_max   = 7;
    for (int f = 0; f < 100; f++) add_random_frame();
    run_until(100 * FLEN, 30000, "rand_timeout");
    compare_bytes("rand");
    start_cyc.delete();

    // Reset after the hi byte of the first sample.
    ready_pct = 100;
    gap_max   = 0;
    for (int w = 0; w < 4; w++) step();
    add_random_frame();
    run_until(4, 100, "midrst_timeout");
    @(posedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    rx_q.delete();
    exp_q.delete();
    tx_q.delete();
    start_cyc.delete();
    s_tvalid   = 1'b0;
    s_acc      = 1'b0;
    gap        = 0;
    fpos       = 0;
    stall_prev = 1'b0;
    model_seq  = '0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    add_random_frame();
    run_until(FLEN, 200, "post_rst_timeout");
    if (rx_q.size() >= 3) begin
      check("post_rst_sync", 32'(rx_q[0]), 32'(SYNC));
      check("post_rst_seq", 32'(rx_q[1]), 32'h00);
      check("post_rst_len", 32'(rx_q[2]), 32'(N));
    end
    compare_bytes("post_rst");
    step();
    step();
    check("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sample_packetizer.md
# sample_packetizer

Upstream framing stage for the FT232H sync-FIFO controller. Accepts 16-bit sample words on an AXI-Stream slave and emits a framed byte stream on an AXI-Stream master that connects directly to the controller's `tdata`/`tvalid`/`tready` input on `sys_clk`. Each frame is sync byte, sequence number, sample count, payload (MSB first) and an 8-bit checksum, so host software can resynchronise and detect loss.

## Interface
- `SAMPLES_PER_PACKET`, default 4: samples per frame. Legal range 1..255; emitted as the LEN byte.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.
- `sys_clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_tdata`  in  16  sample word.
- `s_tvalid`  in  1  sample valid.
- `s_tready`  out  1  sample accepted when `s_tvalid && s_tready`.
- `m_tdata`  out  8  frame byte to the FT232H controller.
- `m_tvalid`  out  1  byte valid.
- `m_tready`  in  1  controller ready; a byte transfers on `m_tvalid && m_tready`.
- `busy`  out  1  high whenever a frame is in progress (state != IDLE).

## Operation
- Frame format: SYNC_BYTE, SEQ, LEN, then for each sample hi byte and lo byte, then CSUM. Total 4 + 2·N bytes.
- SEQ: 8-bit counter, 0 after reset, incremented on the CSUM handshake, wraps 255 -> 0.
- CSUM: 8-bit sum mod 256 of SEQ, LEN and all payload bytes. SYNC is excluded. The accumulator clears in IDLE and adds each byte on its handshake.
- States and transitions:
  - IDLE: `m_tvalid`=0, `s_tready`=0. Goes to SYNC when `s_tvalid`=1; the sample is not consumed.
  - SYNC, SEQ, LEN: drive the corresponding byte. Each advances on its handshake; LEN goes to LOAD.
  - LOAD: `s_tready`=1, `m_tvalid`=0. On `s_tvalid`, captures `s_tdata` into the sample register and goes to HI.
  - HI: drives sample[15:8]; goes to LO on handshake.
  - LO: drives sample[7:0]. On handshake, increments the sample counter and goes to LOAD, or to CSUM if this was sample N.
  - CSUM: drives the accumulated sum. On handshake, increments SEQ and goes to IDLE.
- `s_tready`, `m_tvalid`, `m_tdata` and `busy` decode from registered state/data only; there is no combinational path from `m_tready` or `s_tvalid` to any output.
- AXIS stability: while `m_tvalid && !m_tready`, `m_tdata` holds and state does not change.
- `s_tvalid` dropping in LOAD is legal: the block waits in LOAD with `m_tvalid`=0 and never times out.
- Reset (any time, including mid-frame):
  - Asynchronously forces IDLE, SEQ=0, sample counter=0, accumulator=0.
  - Outputs: `m_tvalid`=0, `m_tdata`=0, `s_tready`=0, `busy`=0.
  - The partial frame is discarded and never resumed.

## Timing
- IDLE -> SYNC: `m_tvalid` rises on the first `sys_clk` edge after `s_tvalid` is sampled high in IDLE (1-cycle latency).
- With `m_tready` held high:
  - Header occupies 3 cycles.
  - Each sample costs 3 cycles (LOAD, HI, LO).
  - CSUM costs 1 cycle; then 1 cycle in IDLE before the next frame's SYNC.
  - Frame period is 5 + 3·N cycles including the IDLE cycle, with N = `SAMPLES_PER_PACKET`.
- Back-to-back frames: if `s_tvalid` is high in IDLE, SYNC follows after exactly one IDLE cycle.
- `m_tready` low stalls the current state indefinitely with no byte loss or duplication.
- Simultaneous reset and handshake: reset wins; the handshake is not counted.

## Test plan
- N=2, samples 16'h1234 then 16'hABCD, `m_tready`=1 -> bytes A5 00 02 12 34 AB CD C0; SEQ becomes 1; `busy` falls after CSUM.
- 257 consecutive N=1 frames, each carrying sample 16'h0000 -> SEQ bytes run 00..FF then 00. For SEQ=s, CSUM = (s+1) mod 256.
- Random `m_tready` toggling (50%) over 100 frames -> byte stream identical to the `m_tready`=1 run. `m_tdata` never changes while `m_tvalid && !m_tready`.
- `s_tvalid` gaps of 0–7 cycles between samples -> `m_tvalid` low only in LOAD/IDLE; frame contents unchanged; `s_tready` high only in LOAD.
- Assert `rst_n` low mid-payload (after hi byte of sample 1 of 4) -> all outputs 0 immediately. The next frame starts with A5 00 04 and contains only new samples.
- Feed the DUT output into the FT232H controller + BFM chain -> PC-side `pc_tdata` sequence equals the expected frame bytes exactly, with no bytes dropped.
